// File: rtl/gate_vector_checker.sv
// Self-test stimulus/checker for the 2-input gates block: walks a/b
// through 00,01,10,11, waits a settle time, compares the 8-bit gate bus
// against golden values and reports per-vector pass, error count, pass.
// Ports: clk, rst_n (async, active low), ena (hold), start (run request),
//   dut_out[7:0] (gate bus in), stim_ab[1:0] (a=bit0, b=bit1 out),
//   busy, done, pass, err_count[2:0], vec_pass[3:0].
// Optional: define GATE_CHK_CAPTURE_EN to add first_fail_vec[1:0] and
//   first_fail_obs[7:0], latching the first mismatching vector of a run.
module gate_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  CHECK_MASK    = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [7:0] dut_out,
  output logic [1:0] stim_ab,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] vec_pass
`ifdef GATE_CHK_CAPTURE_EN
  ,
  output logic [1:0] first_fail_vec,
  output logic [7:0] first_fail_obs
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_v;
  logic [3:0] r_cnt;
  logic [1:0] r_stim;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err;
  logic [3:0] r_vp;
`ifdef GATE_CHK_CAPTURE_EN
  logic [1:0] r_ff_vec;
  logic [7:0] r_ff_obs;
`endif

  logic [7:0] w_gold;
  logic       w_miss;
  logic [2:0] w_err_nxt;

  // Golden bus {b, ~a, xnor, nor, nand, xor, or, and} per {b,a}
  always_comb begin
    w_gold = 8'h00;
    unique case (r_v)
      2'd0: w_gold = 8'h78;
      2'd1: w_gold = 8'h0E;
      2'd2: w_gold = 8'hCE;
      2'd3: w_gold = 8'hA3;
      default: w_gold = 8'h00;
    endcase
  end

  assign w_miss    = |((dut_out ^ w_gold) & CHECK_MASK);
  assign w_err_nxt = r_err + {2'b00, w_miss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_v     <= 2'd0;
      r_cnt   <= 4'd0;
      r_stim  <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 3'd0;
      r_vp    <= 4'd0;
`ifdef GATE_CHK_CAPTURE_EN
      r_ff_vec <= 2'd0;
      r_ff_obs <= 8'd0;
`endif
    end else if (ena) begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_v     <= 2'd0;
            r_stim  <= 2'd0;
            r_cnt   <= 4'd0;
            r_err   <= 3'd0;
            r_vp    <= 4'd0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
`ifdef GATE_CHK_CAPTURE_EN
            r_ff_vec <= 2'd0;
            r_ff_obs <= 8'd0;
`endif
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!w_miss) begin
            r_vp[r_v] <= 1'b1;
          end
          r_err <= w_err_nxt;
`ifdef GATE_CHK_CAPTURE_EN
          // err still zero means this is the run's first failure
          if (w_miss && r_err == 3'd0) begin
            r_ff_vec <= r_v;
            r_ff_obs <= dut_out;
          end
`endif
          if (r_v == 2'd3) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 3'd0);
            r_state <= S_DONE;
          end else begin
            r_v     <= r_v + 2'd1;
            r_stim  <= r_v + 2'd1;
            r_cnt   <= 4'd0;
            r_state <= S_SETTLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stim_ab   = r_stim;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign vec_pass  = r_vp;
`ifdef GATE_CHK_CAPTURE_EN
  assign first_fail_vec = r_ff_vec;
  assign first_fail_obs = r_ff_obs;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: gates model with fault modes, two
// checker instances (full mask and mask 8'hFB), scoreboard of results.
module tb_gate_vector_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  int         mode = 0;
  logic [7:0] dut_out, dut_out2;
  logic [1:0] stim_ab, stim_ab2;
  logic       busy, done, pass, busy2, done2, pass2;
  logic [2:0] err_count, err_count2;
  logic [3:0] vec_pass, vec_pass2;
`ifdef GATE_CHK_CAPTURE_EN
  logic [1:0] ffv, ffv2;
  logic [7:0] ffo, ffo2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Ideal gates with fault injection: 1 = bus forced 0,
  // 2 = xor bit stuck 0, 3 = b bit stuck 1
  function automatic logic [7:0] gates(input logic [1:0] ab, input int m);
    logic a, b;
    logic [7:0] g;
    a = ab[0];
    b = ab[1];
    g = {b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
    if (m == 1) g = 8'h00;
    if (m == 2) g[2] = 1'b0;
    if (m == 3) g[7] = 1'b1;
    return g;
  endfunction

  always_comb dut_out = gates(stim_ab, mode);
  always_comb dut_out2 = gates(stim_ab2, mode);

  gate_vector_checker u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .dut_out(dut_out), .stim_ab(stim_ab), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count),
    .vec_pass(vec_pass)
`ifdef GATE_CHK_CAPTURE_EN
    , .first_fail_vec(ffv), .first_fail_obs(ffo)
`endif
  );

  gate_vector_checker #(.SETTLE_CYCLES(2), .CHECK_MASK(8'hFB)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .dut_out(dut_out2), .stim_ab(stim_ab2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err_count2),
    .vec_pass(vec_pass2)
`ifdef GATE_CHK_CAPTURE_EN
    , .first_fail_vec(ffv2), .first_fail_obs(ffo2)
`endif
  );

  typedef struct {
    int         m;
    logic [2:0] err;
    logic [3:0] vp;
    logic       ps;
    logic [2:0] err2;
    logic [3:0] vp2;
    logic       ps2;
    logic [1:0] fv;
    logic [7:0] fo;
  } rec_t;

  rec_t tbl[5];
  rec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input rec_t r, input int restart_at,
                     input int freeze_at);
    int n;
    int eff;
    int exp_n;
    rec_t e;
    mode = r.m;
    sb.push_back(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clear_busy", busy, 1);
    chk("clear_done", {done, pass}, 0);
    chk("clear_err", err_count, 0);
    chk("clear_vp", vec_pass, 0);
    n = 0;
    eff = 0;
    while (n < 40 && !done) begin
      chk("stim_seq", stim_ab, eff / 3);
      start = (n == restart_at);
      ena = !(freeze_at >= 0 && n >= freeze_at && n < freeze_at + 5);
      @(negedge clk);
      n++;
      if (ena) eff++;
    end
    start = 1'b0;
    ena = 1'b1;
    exp_n = (freeze_at >= 0) ? 17 : 12;
    chk("done_edge", n, exp_n);
    chk("done", done, 1);
    chk("done2", done2, 1);
    chk("busy_end", busy, 0);
    chk("stim_done", stim_ab, 3);
    e = sb.pop_front();
    chk("err_count", err_count, e.err);
    chk("vec_pass", vec_pass, e.vp);
    chk("pass", pass, e.ps);
    chk("err_count2", err_count2, e.err2);
    chk("vec_pass2", vec_pass2, e.vp2);
    chk("pass2", pass2, e.ps2);
`ifdef GATE_CHK_CAPTURE_EN
    chk("first_fail_vec", ffv, e.fv);
    chk("first_fail_obs", ffo, e.fo);
`endif
    repeat (2) @(negedge clk);
    chk("done_hold", {done, stim_ab}, {1'b1, 2'd3});
  endtask

  initial begin
    tbl[0] = '{0, 3'd0, 4'hF, 1'b1, 3'd0, 4'hF, 1'b1, 2'd0, 8'h00};
    tbl[1] = '{1, 3'd4, 4'h0, 1'b0, 3'd4, 4'h0, 1'b0, 2'd0, 8'h00};
    tbl[2] = '{2, 3'd2, 4'b1001, 1'b0, 3'd0, 4'hF, 1'b1, 2'd1, 8'h0A};
    tbl[3] = '{3, 3'd2, 4'b1100, 1'b0, 3'd2, 4'b1100, 1'b0, 2'd0, 8'hF8};
    tbl[4] = '{0, 3'd0, 4'hF, 1'b1, 3'd0, 4'hF, 1'b1, 2'd0, 8'h00};

    repeat (2) @(negedge clk);
    chk("rst_outs", {stim_ab, busy, done, pass, err_count, vec_pass}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {stim_ab, busy, done, pass, err_count, vec_pass}, 0);

    for (int i = 0; i < 4; i++) run(tbl[i], -1, -1);

    // start during SETTLE of vector 1 is ignored
    run(tbl[4], 4, -1);
    // 5-cycle ena stall during SETTLE of vector 2
    run(tbl[2], -1, 7);

    // reset while in CHECK of vector 3
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_rst_busy", {busy, stim_ab}, {1'b1, 2'd3});
    rst_n = 1'b0;
    #1;
    chk("midrst_outs",
        {stim_ab, busy, done, pass, err_count, vec_pass}, 0);
`ifdef GATE_CHK_CAPTURE_EN
    chk("midrst_cap", {ffv, ffo}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {busy, done}, 0);
    run(tbl[0], -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
